// File: rtl/deck_shuffler.sv
// rtl/deck_shuffler.sv - in-place card deck shuffler over a single-port synchronous RAM
// MODE 0 draws swap partners from a Galois LFSR with rejection sampling; MODE 1 reverses the deck.
module deck_shuffler #(
  parameter int          DATA_W    = 6,
  parameter int          ADDR_W    = 6,
  parameter int          DECK_SIZE = 52,
  parameter int          BASE_ADDR = 0,
  parameter int          MODE      = 0,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       seed_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE, DRAW, CHK, RD_I, RD_J, CAP_J, WR_J, WR_I, NEXT, DONE
  } stateT;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DECK_SIZE - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W:0]   DECK_LEN  = (ADDR_W + 1)'(DECK_SIZE);
  localparam logic [ADDR_W:0]   ONE_WIDE  = (ADDR_W + 1)'(1);
  localparam logic [15:0]       LFSR_MASK = 16'hB400;

  stateT             state, stateNext;
  logic              startPrev;
  logic              abortSeen;
  logic [ADDR_W-1:0] idxI;
  logic [ADDR_W-1:0] idxJ;
  logic [ADDR_W-1:0] rangeMask;
  logic [ADDR_W-1:0] cand;
  logic [15:0]       lfsr;
  logic [15:0]       lfsrStep;
  logic [DATA_W-1:0] cardI;
  logic [DATA_W-1:0] cardJ;
  logic              startAccept;
  logic              drawOk;
  logic              lastCard;
  logic              abortHit;

  // Smear the top set bit of i downward: smallest 2^k-1 that covers i.
  always_comb begin
    rangeMask = idxI;
    for (int s = 1; s < ADDR_W; s = s * 2) begin
      rangeMask = rangeMask | (rangeMask >> s);
    end
  end

  assign lfsrStep    = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
  assign cand        = lfsr[ADDR_W-1:0] & rangeMask;
  assign drawOk      = (MODE == 1) || (cand <= idxI);
  assign abortHit    = abortSeen | abort;
  assign startAccept = (state == IDLE) && start && !startPrev;

  always_comb begin
    lastCard = 1'b0;
    if (MODE == 1) begin
      lastCard = ({1'b0, idxI} - ONE_WIDE) <= (DECK_LEN - {1'b0, idxI});
    end else begin
      lastCard = (idxI == ONE);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
    case (state)
      IDLE:  if (startAccept) stateNext = DRAW;
      DRAW:  if (drawOk) stateNext = CHK;
      CHK:   stateNext = (idxJ == idxI) ? NEXT : RD_I;
      RD_I: begin
        mem_addr  = BASE + idxI;
        stateNext = RD_J;
      end
      RD_J: begin
        mem_addr  = BASE + idxJ;
        stateNext = CAP_J;
      end
      CAP_J: stateNext = WR_J;
      WR_J: begin
        mem_addr  = BASE + idxJ;
        mem_wdata = cardI;
        mem_we    = 1'b1;
        stateNext = WR_I;
      end
      WR_I: begin
        mem_addr  = BASE + idxI;
        mem_wdata = cardJ;
        mem_we    = 1'b1;
        stateNext = NEXT;
      end
      NEXT: begin
        if (abortHit) begin
          stateNext = IDLE;
        end else if (lastCard) begin
          stateNext = DONE;
        end else begin
          stateNext = DRAW;
        end
      end
      DONE:  if (!start) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Abort is only acted on in NEXT, so a swap in flight always finishes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      startPrev <= 1'b0;
      abortSeen <= 1'b0;
      idxI      <= '0;
      idxJ      <= '0;
      lfsr      <= SEED;
      cardI     <= '0;
      cardJ     <= '0;
    end else begin
      startPrev <= start;
      if (startAccept || state == NEXT) begin
        abortSeen <= 1'b0;
      end else if (abort) begin
        abortSeen <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (startAccept) begin
            idxI <= LAST_IDX;
            lfsr <= (seed_in == 16'h0000) ? SEED : seed_in;
          end
        end
        DRAW: begin
          if (MODE == 1) begin
            idxJ <= LAST_IDX - idxI;
          end else begin
            lfsr <= lfsrStep;
            if (drawOk) idxJ <= cand;
          end
        end
        RD_J:  cardI <= mem_rdata;
        CAP_J: cardJ <= mem_rdata;
        NEXT: begin
          if (!abortHit && !lastCard) idxI <= idxI - ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deck_shuffler.sv
// tb/tb_deck_shuffler.sv - bench for deck_shuffler: reverse and Fisher-Yates runs against an array model
module tb_deck_shuffler;

  localparam int N = 52;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        startS [3];
  logic        abortS [3];
  logic [15:0] seedS  [3];
  logic [5:0]  rdS    [3];
  logic [5:0]  addrS  [3];
  logic [5:0]  wdS    [3];
  logic        weS    [3];
  logic        busyS  [3];
  logic        doneS  [3];
  logic [2:0]  ramInit = 3'b000;
  logic [5:0]  ram [3][64];
  int          wrCnt [3];
  int          expDeck [64];
  int          nCmp = 0;
  int          nFail = 0;

  deck_shuffler #(.MODE(0)) dut0 (
    .clock(clock), .reset(reset), .start(startS[0]), .abort(abortS[0]), .seed_in(seedS[0]),
    .mem_rdata(rdS[0]), .mem_addr(addrS[0]), .mem_wdata(wdS[0]), .mem_we(weS[0]),
    .busy(busyS[0]), .done(doneS[0]));

  deck_shuffler #(.MODE(1)) dut1 (
    .clock(clock), .reset(reset), .start(startS[1]), .abort(abortS[1]), .seed_in(seedS[1]),
    .mem_rdata(rdS[1]), .mem_addr(addrS[1]), .mem_wdata(wdS[1]), .mem_we(weS[1]),
    .busy(busyS[1]), .done(doneS[1]));

  deck_shuffler #(.MODE(1), .DECK_SIZE(2), .BASE_ADDR(5)) dut2 (
    .clock(clock), .reset(reset), .start(startS[2]), .abort(abortS[2]), .seed_in(seedS[2]),
    .mem_rdata(rdS[2]), .mem_addr(addrS[2]), .mem_wdata(wdS[2]), .mem_we(weS[2]),
    .busy(busyS[2]), .done(doneS[2]));

  // Read-first synchronous RAM per instance, initialised to ram[a] = a on request.
  always @(posedge clock) begin
    for (int d = 0; d < 3; d++) begin
      if (ramInit[d]) begin
        for (int k = 0; k < 64; k++) ram[d][k] <= 6'(k);
        wrCnt[d] <= 0;
      end else if (weS[d]) begin
        ram[d][addrS[d]] <= wdS[d];
        wrCnt[d] <= wrCnt[d] + 1;
      end
      rdS[d] <= ram[d][addrS[d]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input int d, input string tag);
    check(tag, {17'd0, weS[d], busyS[d], doneS[d], addrS[d], wdS[d]}, 32'd0);
  endtask

  task automatic initRam(input int d);
    @(negedge clock);
    ramInit[d] = 1'b1;
    @(negedge clock);
    ramInit[d] = 1'b0;
  endtask

  function automatic logic [15:0] lfsrNext(input logic [15:0] r);
    return r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
  endfunction

  // Fisher-Yates on an int array; also yields cycle timing from the per-card latency rule.
  task automatic fyModel(input logic [15:0] seedIn, input int abortAt,
                         output int total, output int rdj, output int nsw,
                         output int fc, output bit fs);
    logic [15:0] r;
    int cyc, m, cand, tmp;
    r = (seedIn == 16'h0) ? 16'hACE1 : seedIn;
    for (int k = 0; k < 64; k++) expDeck[k] = k;
    cyc = 0; nsw = 0; rdj = -1; fc = 0; fs = 1'b0;
    for (int i = N - 1; i >= 1; i--) begin
      m = 1;
      while (m < i) m = m * 2 + 1;
      cand = int'(r) & m;
      r = lfsrNext(r);
      cyc++;
      while (cand > i) begin
        cand = int'(r) & m;
        r = lfsrNext(r);
        cyc++;
      end
      cyc++;
      if (cand != i) begin
        nsw++;
        if (nsw == abortAt) rdj = cyc + 1;
        tmp = expDeck[i]; expDeck[i] = expDeck[cand]; expDeck[cand] = tmp;
        cyc += 5;
      end
      cyc++;
      if (i == N - 1) begin
        fc = cyc;
        fs = (cand == i);
      end
      if (abortAt > 0 && nsw == abortAt) break;
    end
    total = cyc;
  endtask

  task automatic runFy(input logic [15:0] seedIn, input int abortAt, input bit glitch, input string tag);
    int total, rdj, nsw, fc, badBusy, bad;
    bit fs;
    bit seen [64];
    fyModel(seedIn, abortAt, total, rdj, nsw, fc, fs);
    initRam(0);
    seedS[0]  = seedIn;
    startS[0] = 1'b1;
    badBusy   = 0;
    for (int c = 0; c < total; c++) begin
      @(negedge clock);
      if (busyS[0] !== 1'b1 || doneS[0] !== 1'b0) badBusy++;
      abortS[0] = (abortAt > 0 && c == rdj);
      if (glitch && c == 3) startS[0] = 1'b0;
      if (glitch && c == 4) startS[0] = 1'b1;
      if (fs && c == fc) check({tag, " self-swap writes"}, wrCnt[0], 0);
    end
    abortS[0] = 1'b0;
    @(negedge clock);
    check({tag, " busy during run"}, badBusy, 0);
    check({tag, " done at end"}, doneS[0], (abortAt > 0) ? 0 : 1);
    check({tag, " busy at end"}, busyS[0], 0);
    check({tag, " writes"}, wrCnt[0], 2 * nsw);
    bad = 0;
    for (int k = 0; k < N; k++) if (ram[0][k] !== 6'(expDeck[k])) bad++;
    check({tag, " ram vs model"}, bad, 0);
    bad = 0;
    for (int k = 0; k < 64; k++) seen[k] = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (ram[0][k] >= 6'(N) || seen[ram[0][k]]) bad++;
      else seen[ram[0][k]] = 1'b1;
    end
    check({tag, " permutation"}, bad, 0);
    repeat (3) @(negedge clock);
    if (abortAt > 0) begin
      check({tag, " no restart after abort"}, busyS[0], 0);
      startS[0] = 1'b0;
      @(negedge clock);
    end else begin
      check({tag, " done holds"}, doneS[0], 1);
      startS[0] = 1'b0;
      @(negedge clock);
      check({tag, " done release"}, doneS[0], 0);
    end
  endtask

  task automatic runRev(input int d, input int n, input int base, input string tag);
    int total, badBusy, bad, expv;
    total = (n / 2) * 8;
    initRam(d);
    startS[d] = 1'b1;
    badBusy   = 0;
    for (int c = 0; c < total; c++) begin
      @(negedge clock);
      if (busyS[d] !== 1'b1 || doneS[d] !== 1'b0) badBusy++;
    end
    @(negedge clock);
    check({tag, " busy during run"}, badBusy, 0);
    check({tag, " done"}, doneS[d], 1);
    check({tag, " busy at end"}, busyS[d], 0);
    check({tag, " writes"}, wrCnt[d], 2 * (n / 2));
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      expv = (a >= base && a < base + n) ? (2 * base + n - 1 - a) : a;
      if (ram[d][a] !== 6'(expv)) bad++;
    end
    check({tag, " ram reversed"}, bad, 0);
    repeat (4) @(negedge clock);
    check({tag, " done holds"}, doneS[d], 1);
    startS[d] = 1'b0;
    @(negedge clock);
    check({tag, " done release"}, doneS[d], 0);
  endtask

  initial begin
    logic [15:0] s;
    int total, rdj, nsw, fc, found;
    bit fs;
    for (int d = 0; d < 3; d++) begin
      startS[d] = 1'b0;
      abortS[d] = 1'b0;
      seedS[d]  = 16'h0;
    end

    repeat (3) @(negedge clock);
    for (int d = 0; d < 3; d++) checkIdle(d, "outputs held in reset");
    reset = 1'b0;
    @(negedge clock);
    checkIdle(1, "idle after reset release");

    initRam(1);
    startS[1] = 1'b1;
    for (int c = 0; c <= 5; c++) @(negedge clock);
    check("WR_J we", weS[1], 1);
    check("WR_J addr", addrS[1], 0);
    check("WR_J wdata", wdS[1], 51);
    reset = 1'b1;
    #1;
    checkIdle(1, "async reset mid-WR_J");
    @(negedge clock);
    checkIdle(1, "reset held");
    startS[1] = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checkIdle(1, "idle after mid-run reset");

    runRev(1, 52, 0, "rev52");
    runRev(2, 2, 5, "rev2");

    runFy(16'h1234, 0, 1'b0, "fy1234");
    runFy(16'h1234, 0, 1'b1, "fy1234 repeat start-pulse");
    runFy(16'h0000, 0, 1'b0, "fy seed0");
    runFy(16'hACE1, 0, 1'b0, "fy seedACE1");
    runFy(16'($urandom_range(1, 65535)), 0, 1'b0, "fy random");

    found = 0;
    s = 16'h0001;
    for (int t = 0; t < 5000 && found == 0; t++) begin
      s = 16'($urandom_range(1, 65535));
      fyModel(s, 0, total, rdj, nsw, fc, fs);
      if (fs) found = 1;
    end
    check("self-swap seed found", found, 1);
    if (found == 1) runFy(s, 0, 1'b0, "fy self-swap");

    runFy(16'($urandom_range(1, 65535)), 10, 1'b0, "fy abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
